// File: rtl/rvecc_scrub_ctrl.sv
// ECC scrub controller: queues single-bit-error corrected words for write-back,
// counts single/double errors and logs the first double-error address.
module rvecc_scrub_ctrl #(
  parameter int AW    = 16,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             rd_valid,
  input  logic [AW-1:0]    rd_addr,
  input  logic [31:0]      rd_data,
  input  logic [6:0]       rd_ecc,
  input  logic             rd_sb_err,
  input  logic             rd_db_err,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [AW-1:0]    wb_addr,
  output logic [31:0]      wb_data,
  output logic [6:0]       wb_ecc,
  output logic [CNT_W-1:0] sb_cnt,
  output logic [CNT_W-1:0] db_cnt,
  output logic             db_flag,
  output logic [AW-1:0]    db_addr,
  output logic             ovf
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [6:0]    ecc;
  } ent_t;

  ent_t [DEPTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0] vld_q, vld_d, hit;
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] sb_cnt_q, sb_cnt_d, db_cnt_q, db_cnt_d;
  logic [AW-1:0]    db_addr_q, db_addr_d;
  logic             db_flag_q, db_flag_d, ovf_q, ovf_d;
  logic             sb_evt, db_evt, enq_req, full, deq, drop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  // A read flagged both single and double is treated as a double error.
  assign sb_evt   = rd_valid & rd_sb_err & ~rd_db_err;
  assign db_evt   = rd_valid & rd_db_err;
  assign enq_req  = sb_evt & en;
  assign full     = &vld_q;
  assign wb_valid = |vld_q;
  assign deq      = wb_valid & wb_ready;
  assign wb_addr  = mem_q[head_q].addr;
  assign wb_data  = mem_q[head_q].data;
  assign wb_ecc   = mem_q[head_q].ecc;

  // The head leaving this cycle cannot absorb a merge; a fresh entry is taken.
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    assign hit[i] = vld_q[i] && (mem_q[i].addr == rd_addr) && !(deq && head_q == PW'(i));
  end

  always_comb begin
    mem_d  = mem_q;
    vld_d  = vld_q;
    head_d = head_q;
    tail_d = tail_q;
    drop   = 1'b0;
    if (deq) begin
      vld_d[head_q] = 1'b0;
      head_d        = ptr_inc(head_q);
    end
    if (enq_req) begin
      if (|hit) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (hit[i]) begin
            mem_d[i].data = rd_data;
            mem_d[i].ecc  = rd_ecc;
          end
        end
      end else if (!full || deq) begin
        mem_d[tail_q] = {rd_addr, rd_data, rd_ecc};
        vld_d[tail_q] = 1'b1;
        tail_d        = ptr_inc(tail_q);
      end else begin
        drop = 1'b1;
      end
    end
  end

  always_comb begin
    sb_cnt_d  = sb_cnt_q;
    db_cnt_d  = db_cnt_q;
    db_flag_d = db_flag_q;
    db_addr_d = db_addr_q;
    ovf_d     = ovf_q | drop;
    if (sb_evt && sb_cnt_q != '1) sb_cnt_d = sb_cnt_q + CNT_W'(1);
    if (db_evt && db_cnt_q != '1) db_cnt_d = db_cnt_q + CNT_W'(1);
    if (db_evt && !db_flag_q) begin
      db_flag_d = 1'b1;
      db_addr_d = rd_addr;
    end
    if (clr) begin
      sb_cnt_d  = '0;
      db_cnt_d  = '0;
      db_flag_d = 1'b0;
      db_addr_d = '0;
      ovf_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q     <= '0;
      vld_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      sb_cnt_q  <= '0;
      db_cnt_q  <= '0;
      db_flag_q <= 1'b0;
      db_addr_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      vld_q     <= vld_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      sb_cnt_q  <= sb_cnt_d;
      db_cnt_q  <= db_cnt_d;
      db_flag_q <= db_flag_d;
      db_addr_q <= db_addr_d;
      ovf_q     <= ovf_d;
    end
  end

  assign sb_cnt  = sb_cnt_q;
  assign db_cnt  = db_cnt_q;
  assign db_flag = db_flag_q;
  assign db_addr = db_addr_q;
  assign ovf     = ovf_q;
endmodule

// File: tb/tb_rvecc_scrub_ctrl.sv
// Bench for rvecc_scrub_ctrl: directed scenarios plus random traffic, checked
// against a queue-based reference model by a negedge monitor.
module tb_rvecc_scrub_ctrl;
  localparam int AW = 16, DEPTH = 2, CNT_W = 2;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b1, clr = 1'b0, rd_valid = 1'b0, rd_sb_err = 1'b0, rd_db_err = 1'b0;
  logic wb_ready = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [31:0] rd_data = '0;
  logic [6:0] rd_ecc = '0;
  logic wb_valid, db_flag, ovf;
  logic [AW-1:0] wb_addr, db_addr;
  logic [31:0] wb_data;
  logic [6:0] wb_ecc;
  logic [CNT_W-1:0] sb_cnt, db_cnt;

  always #5 clk = ~clk;

  rvecc_scrub_ctrl #(.AW(AW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .rd_valid(rd_valid), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_ecc(rd_ecc), .rd_sb_err(rd_sb_err), .rd_db_err(rd_db_err),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_ecc(wb_ecc), .sb_cnt(sb_cnt), .db_cnt(db_cnt), .db_flag(db_flag),
    .db_addr(db_addr), .ovf(ovf)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic [6:0]    e;
  } ent_t;

  ent_t exp_q[$];
  int m_sb = 0, m_db = 0;
  logic m_flag = 1'b0, m_ovf = 1'b0;
  logic [AW-1:0] m_dbaddr = '0;
  bit m_rstd = 1'b1, started = 1'b0;
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor + reference model: compares the state presented now, then advances
  // the model with the inputs that the next rising edge will sample.
  always @(negedge clk) begin
    if (started) begin
      bit sb, db;
      int hit;
      chk("sb_cnt", sb_cnt, m_sb);
      chk("db_cnt", db_cnt, m_db);
      chk("db_flag", db_flag, m_flag);
      chk("db_addr", db_addr, m_dbaddr);
      chk("ovf", ovf, m_ovf);
      chk("wb_valid", wb_valid, exp_q.size() != 0);
      if (m_rstd) begin
        chk("rst_wb_addr", wb_addr, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_ecc", wb_ecc, 0);
      end
      if (exp_q.size() != 0) begin
        chk("wb_addr", wb_addr, exp_q[0].a);
        chk("wb_data", wb_data, exp_q[0].d);
        chk("wb_ecc", wb_ecc, exp_q[0].e);
        if (wb_ready) void'(exp_q.pop_front());
      end
      m_rstd = 1'b0;
      sb = rd_valid && rd_sb_err && !rd_db_err;
      db = rd_valid && rd_db_err;
      if (sb && en) begin
        hit = -1;
        foreach (exp_q[i]) if (exp_q[i].a == rd_addr) hit = i;
        if (hit >= 0) begin
          exp_q[hit].d = rd_data;
          exp_q[hit].e = rd_ecc;
        end else if (exp_q.size() < DEPTH) begin
          exp_q.push_back('{a: rd_addr, d: rd_data, e: rd_ecc});
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (sb) m_sb = (m_sb < CMAX) ? m_sb + 1 : CMAX;
      if (db) begin
        m_db = (m_db < CMAX) ? m_db + 1 : CMAX;
        if (!m_flag) begin
          m_flag = 1'b1;
          m_dbaddr = rd_addr;
        end
      end
      if (clr) begin
        m_sb = 0; m_db = 0; m_flag = 1'b0; m_dbaddr = '0; m_ovf = 1'b0;
      end
      if (rst) begin
        m_sb = 0; m_db = 0; m_flag = 1'b0; m_dbaddr = '0; m_ovf = 1'b0;
        exp_q.delete();
        m_rstd = 1'b1;
      end
    end
  end

  // One clock of stimulus; returns 2 time units after the edge that sampled it.
  task automatic cyc(input bit v, input logic [AW-1:0] a, input logic [31:0] d,
                     input logic [6:0] e, input bit sb, input bit db, input bit rdy,
                     input bit en_i = 1'b1, input bit clr_i = 1'b0, input bit rst_i = 1'b0);
    rd_valid = v; rd_addr = a; rd_data = d; rd_ecc = e;
    rd_sb_err = sb; rd_db_err = db; wb_ready = rdy;
    en = en_i; clr = clr_i; rst = rst_i;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input bit rdy, input int n = 1);
    for (int i = 0; i < n; i++) cyc(0, '0, '0, '0, 0, 0, rdy);
  endtask

  task automatic clr_pulse();
    cyc(0, '0, '0, '0, 0, 0, 0, 1, 1);
  endtask

  initial begin
    cyc(0, '0, '0, '0, 0, 0, 0, 1, 0, 1);
    started = 1'b1;
    idle(0);

    // Single error, stalled then drained
    cyc(1, 16'h0010, 32'hDEADBEEF, 7'h2A, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("t1_hold_valid", wb_valid, 1);
      chk("t1_hold_data", wb_data, 32'hDEADBEEF);
      idle(0);
    end
    idle(1);
    chk("t1_drained", wb_valid, 0);
    chk("t1_sb_cnt", sb_cnt, 1);

    // Overflow, then full-with-dequeue acceptance
    clr_pulse();
    cyc(1, 16'h1, 32'h11, 7'h1, 1, 0, 0);
    cyc(1, 16'h2, 32'h22, 7'h2, 1, 0, 0);
    cyc(1, 16'h3, 32'h33, 7'h3, 1, 0, 0);
    chk("t2_ovf", ovf, 1);
    chk("t2_sb_cnt", sb_cnt, 3);
    chk("t2_head", wb_addr, 16'h1);
    idle(1, 2);
    clr_pulse();
    cyc(1, 16'h1, 32'h11, 7'h1, 1, 0, 0);
    cyc(1, 16'h2, 32'h22, 7'h2, 1, 0, 0);
    cyc(1, 16'h3, 32'h33, 7'h3, 1, 0, 1);
    chk("t2_no_ovf", ovf, 0);
    chk("t2_head2", wb_addr, 16'h2);
    idle(1, 2);

    // Merge while stalled
    cyc(1, 16'h5, 32'h1, 7'h11, 1, 0, 0);
    cyc(1, 16'h5, 32'h2, 7'h12, 1, 0, 0);
    chk("t3_merge_data", wb_data, 32'h2);
    idle(1);
    chk("t3_single_entry", wb_valid, 0);

    // Double errors
    clr_pulse();
    cyc(1, 16'h7, 32'h0, 7'h0, 0, 1, 0);
    cyc(1, 16'h9, 32'h0, 7'h0, 0, 1, 0);
    chk("t4_db_cnt", db_cnt, 2);
    chk("t4_db_addr", db_addr, 16'h7);
    chk("t4_db_flag", db_flag, 1);
    chk("t4_no_wb", wb_valid, 0);
    cyc(1, 16'hB, 32'h0, 7'h0, 1, 1, 0);
    chk("t4_both_db", db_cnt, 3);
    chk("t4_both_sb", sb_cnt, 0);

    // Saturation and clr priority
    clr_pulse();
    for (int i = 0; i < 5; i++) cyc(1, 16'h40 + 16'(i), 32'(i), 7'(i), 1, 0, 1);
    chk("t5_sat", sb_cnt, 3);
    idle(1, 2);
    cyc(1, 16'h50, 32'h0, 7'h0, 0, 1, 0, 1, 1);
    chk("t5_clr_db_cnt", db_cnt, 0);
    chk("t5_clr_db_flag", db_flag, 0);

    // en=0 blocks enqueue only; reset mid-stall
    clr_pulse();
    cyc(1, 16'h20, 32'hA0, 7'h20, 1, 0, 0);
    cyc(1, 16'h21, 32'hA1, 7'h21, 1, 0, 0);
    cyc(1, 16'h22, 32'hA2, 7'h22, 1, 0, 0, 0);
    chk("t6_sb_cnt", sb_cnt, 3);
    chk("t6_no_ovf", ovf, 0);
    idle(1, 2);
    chk("t6_drained", wb_valid, 0);
    cyc(1, 16'h30, 32'hB0, 7'h30, 1, 0, 0);
    cyc(1, 16'h31, 32'hB1, 7'h31, 1, 1, 0);
    cyc(0, '0, '0, '0, 0, 0, 0, 1, 0, 1);
    chk("t6_rst_valid", wb_valid, 0);
    chk("t6_rst_cnt", {sb_cnt, db_cnt, db_flag, ovf}, 0);
    chk("t6_rst_wb_data", wb_data, 0);
    idle(0);

    // Random traffic over a small address set to exercise merges and drops
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 9) < 7, AW'($urandom_range(0, 7)), $urandom, 7'($urandom),
          $urandom_range(0, 1), $urandom_range(0, 5) == 0, $urandom_range(0, 1),
          $urandom_range(0, 19) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, 99) == 0);
    end
    idle(1, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
